// File: rtl/opb_reg_target.sv
// OPB responder register bank: ID, scratch, control, sticky status with
// IRQ mask, 2 kHz tick counter and read/write access counters.
// Read data is registered one cycle after the strobe and is zero otherwise,
// so OPB_DO can be OR-combined with other targets.
module opb_reg_target #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter logic [31:0] ID_VALUE   = 32'h4750_0001,
  parameter logic [31:0] DEAD_VALUE = 32'hDEAD_BEEF
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [31:0] OPB_ADDR,
  input  logic [31:0] OPB_DI,
  output logic [31:0] OPB_DO,
  input  logic        OPB_RE,
  input  logic        OPB_WE,
  input  logic        PULSE_2KHZ,
  input  logic [31:0] EVENT_IN,
  output logic [31:0] CTRL_OUT,
  output logic        IRQ
);

  localparam logic [3:0] OFF_ID   = 4'h0;
  localparam logic [3:0] OFF_SCR  = 4'h1;
  localparam logic [3:0] OFF_CTRL = 4'h2;
  localparam logic [3:0] OFF_STAT = 4'h3;
  localparam logic [3:0] OFF_MASK = 4'h4;
  localparam logic [3:0] OFF_TICK = 4'h5;
  localparam logic [3:0] OFF_ACC  = 4'h6;

  logic [31:0] r_scratch, r_ctrl, r_status, r_mask, r_tick;
  logic [15:0] r_wr_cnt, r_rd_cnt;
  logic        w_sel, w_wr, w_rd;
  logic [3:0]  w_off;
  logic [31:0] w_rdata, w_w1c;

  assign w_sel    = (OPB_ADDR[31:6] == BASE_ADDR[31:6]);
  assign w_off    = OPB_ADDR[5:2];
  // A simultaneous RE+WE is a write only; no read data, no read count.
  assign w_wr     = OPB_WE && w_sel;
  assign w_rd     = OPB_RE && !OPB_WE && w_sel;
  assign w_w1c    = (w_wr && w_off == OFF_STAT) ? OPB_DI : 32'h0;
  assign CTRL_OUT = r_ctrl;

  // Read mux over pre-update register state.
  always_comb begin
    w_rdata = DEAD_VALUE;
    case (w_off)
      OFF_ID:   w_rdata = ID_VALUE;
      OFF_SCR:  w_rdata = r_scratch;
      OFF_CTRL: w_rdata = r_ctrl;
      OFF_STAT: w_rdata = r_status;
      OFF_MASK: w_rdata = r_mask;
      OFF_TICK: w_rdata = r_tick;
      OFF_ACC:  w_rdata = {r_wr_cnt, r_rd_cnt};
      default:  w_rdata = DEAD_VALUE;
    endcase
  end

  // Registered read data, forced to zero when no read is being returned.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) OPB_DO <= 32'h0;
    else         OPB_DO <= w_rd ? w_rdata : 32'h0;
  end

  // Plain RW registers.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      r_scratch <= 32'h0;
      r_ctrl    <= 32'h0;
      r_mask    <= 32'h0;
    end else if (w_wr) begin
      if (w_off == OFF_SCR)  r_scratch <= OPB_DI;
      if (w_off == OFF_CTRL) r_ctrl    <= OPB_DI;
      if (w_off == OFF_MASK) r_mask    <= OPB_DI;
    end
  end

  // Sticky status: W1C, with a coincident event winning over the clear.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) r_status <= 32'h0;
    else         r_status <= (r_status & ~w_w1c) | EVENT_IN;
  end

  // Interrupt from current status and mask, so it lags changes by one cycle.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) IRQ <= 1'b0;
    else         IRQ <= |(r_status & r_mask);
  end

  // Tick counter: a write load takes priority and drops a coincident pulse.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST)                        r_tick <= 32'h0;
    else if (w_wr && w_off == OFF_TICK) r_tick <= OPB_DI;
    else if (PULSE_2KHZ)                r_tick <= r_tick + 32'h1;
  end

  // Saturating counters of accepted writes and reads at any offset.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      r_wr_cnt <= 16'h0;
      r_rd_cnt <= 16'h0;
    end else begin
      if (w_wr && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'h1;
      if (w_rd && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'h1;
    end
  end

endmodule

// File: tb/tb_opb_reg_target.sv
// Bench for opb_reg_target: read data goes through a scoreboard queue popped
// by a monitor on the falling edge; sideband outputs are checked inline.
module tb_opb_reg_target;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST = 1'b1;
  logic [31:0] OPB_ADDR = '0, OPB_DI = '0, OPB_DO, EVENT_IN = '0, CTRL_OUT;
  logic        OPB_RE = 1'b0, OPB_WE = 1'b0, PULSE_2KHZ = 1'b0, IRQ;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  logic        issue = 1'b0, pend = 1'b0;

  opb_reg_target dut (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .OPB_ADDR(OPB_ADDR), .OPB_DI(OPB_DI),
    .OPB_DO(OPB_DO), .OPB_RE(OPB_RE), .OPB_WE(OPB_WE), .PULSE_2KHZ(PULSE_2KHZ),
    .EVENT_IN(EVENT_IN), .CTRL_OUT(CTRL_OUT), .IRQ(IRQ)
  );

  always #5 OPB_CLK = ~OPB_CLK;

  // Remember whether the strobe just sampled should produce read data.
  always @(posedge OPB_CLK) pend <= issue;

  // Monitor: expected read data on the cycle after a read, zero otherwise.
  always @(negedge OPB_CLK) begin
    if (!OPB_RST) begin
      n_chk++;
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_data: got %h but no read expected", OPB_DO);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (OPB_DO !== e) begin
            n_fail++;
            $display("FAIL rd_data: got %h exp %h", OPB_DO, e);
          end
        end
      end else if (OPB_DO !== 32'h0) begin
        n_fail++;
        $display("FAIL do_idle: got %h exp 00000000", OPB_DO);
      end
    end
  end

  // One bus cycle, driven on the falling edge.
  task automatic acc(input logic re, we, input logic [31:0] addr, di, exp);
    @(negedge OPB_CLK);
    OPB_RE = re; OPB_WE = we; OPB_ADDR = addr; OPB_DI = di;
    issue = re && !we && (addr[31:6] == BASE[31:6]);
    if (issue) exp_q.push_back(exp);
  endtask

  task automatic wr(input logic [31:0] addr, di);
    acc(1'b0, 1'b1, addr, di, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, exp);
    acc(1'b1, 1'b0, addr, 32'h0, exp);
  endtask

  task automatic idle();
    acc(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge OPB_CLK);
    OPB_RST = 1'b1; OPB_RE = 0; OPB_WE = 0; issue = 0;
    EVENT_IN = '0; PULSE_2KHZ = 0;
    repeat (2) @(negedge OPB_CLK);
    OPB_RST = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge OPB_CLK);
    n_chk += 3;
    if (OPB_DO !== 32'h0) begin n_fail++; $display("FAIL rst_do: got %h exp 0", OPB_DO); end
    if (CTRL_OUT !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h exp 0", CTRL_OUT); end
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b exp 0", IRQ); end
    OPB_RST = 1'b0;
    rd(BASE + 32'h00, 32'h4750_0001);
    idle(); idle();
    rd(BASE + 32'h04, 32'h0);
    idle();
  endtask

  task automatic test_scratch_ctrl();
    wr(BASE + 32'h04, 32'hA5A5_5A5A);
    wr(BASE + 32'h08, 32'h0000_00FF);
    rd(BASE + 32'h04, 32'hA5A5_5A5A);
    rd(BASE + 32'h08, 32'h0000_00FF);
    idle();
    n_chk++;
    if (CTRL_OUT !== 32'hFF) begin n_fail++; $display("FAIL ctrl_out: got %h exp 000000ff", CTRL_OUT); end
    wr(32'h0000_2004, 32'h1111_2222);
    rd(BASE + 32'h04, 32'hA5A5_5A5A);
    rd(32'h0000_2004, 32'h0);
    idle(); idle();
  endtask

  task automatic test_status_irq();
    @(negedge OPB_CLK); EVENT_IN = 32'h8;
    idle();
    EVENT_IN = 32'h0;
    wr(BASE + 32'h10, 32'h8);
    idle();
    n_chk++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_lag: got %b exp 0", IRQ); end
    idle();
    n_chk++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b exp 1", IRQ); end
    rd(BASE + 32'h0C, 32'h8);
    wr(BASE + 32'h0C, 32'h8); EVENT_IN = 32'h8;
    rd(BASE + 32'h0C, 32'h8); EVENT_IN = 32'h0;
    wr(BASE + 32'h0C, 32'h8);
    idle();
    n_chk++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b exp 1", IRQ); end
    idle();
    n_chk++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_clr: got %b exp 0", IRQ); end
    rd(BASE + 32'h0C, 32'h0);
    // Event landing in the same cycle as a read is not yet visible.
    rd(BASE + 32'h0C, 32'h0); EVENT_IN = 32'h4;
    rd(BASE + 32'h0C, 32'h4); EVENT_IN = 32'h0;
    wr(BASE + 32'h0C, 32'h4);
    rd(BASE + 32'h0C, 32'h0);
    idle();
  endtask

  task automatic test_tick();
    wr(BASE + 32'h14, 32'hFFFF_FFFE);
    idle(); PULSE_2KHZ = 1;
    idle(); idle();
    idle(); PULSE_2KHZ = 0;
    rd(BASE + 32'h14, 32'h0000_0001);
    wr(BASE + 32'h14, 32'h10); PULSE_2KHZ = 1;
    rd(BASE + 32'h14, 32'h10); PULSE_2KHZ = 0;
    idle();
  endtask

  task automatic test_access_cnt();
    do_reset();
    wr(BASE + 32'h04, 32'h7);
    wr(BASE + 32'h08, 32'h0);
    wr(BASE + 32'h18, 32'hFFFF_FFFF);
    rd(BASE + 32'h00, 32'h4750_0001);
    rd(BASE + 32'h04, 32'h7);
    rd(BASE + 32'h18, 32'h0003_0002);
    rd(BASE + 32'h20, 32'hDEAD_BEEF);
    rd(BASE + 32'h18, 32'h0003_0004);
    acc(1'b1, 1'b1, BASE + 32'h04, 32'h1, 32'h0);
    rd(BASE + 32'h04, 32'h1);
    rd(BASE + 32'h18, 32'h0004_0006);
    idle();
  endtask

  task automatic test_reset_mid();
    wr(BASE + 32'h04, 32'h1234);
    wr(BASE + 32'h08, 32'h55);
    wr(BASE + 32'h10, 32'h1); EVENT_IN = 32'h1;
    idle(); EVENT_IN = 32'h0;
    idle(); idle();
    n_chk++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL mid_irq_pre: got %b exp 1", IRQ); end
    // Read whose data cycle is cut short by reset; no scoreboard entry.
    @(negedge OPB_CLK);
    OPB_RE = 1; OPB_ADDR = BASE + 32'h04; issue = 0;
    @(posedge OPB_CLK); #1;
    OPB_RE = 0;
    n_chk++;
    if (OPB_DO !== 32'h1234) begin n_fail++; $display("FAIL mid_data: got %h exp 00001234", OPB_DO); end
    OPB_RST = 1'b1; #1;
    n_chk += 3;
    if (OPB_DO !== 32'h0) begin n_fail++; $display("FAIL mid_do: got %h exp 0", OPB_DO); end
    if (CTRL_OUT !== 32'h0) begin n_fail++; $display("FAIL mid_ctrl: got %h exp 0", CTRL_OUT); end
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL mid_irq: got %b exp 0", IRQ); end
    @(negedge OPB_CLK); OPB_RST = 1'b0;
    rd(BASE + 32'h04, 32'h0);
    rd(BASE + 32'h10, 32'h0);
    rd(BASE + 32'h0C, 32'h0);
    rd(BASE + 32'h18, 32'h0000_0003);
    idle(); idle();
  endtask

  initial begin
    test_reset();
    test_scratch_ctrl();
    test_status_irq();
    test_tick();
    test_access_cnt();
    test_reset_mid();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
